mem_dump_ctrl: RTL



---
 rtl/mem_dump_ctrl_pkg.sv | 19 +
 rtl/dump_range_ctr.sv | 52 +++++
 rtl/mem_dump_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_dump_ctrl_pkg.sv
// Shared definitions for the memory dump controller: FSM states and the default
// bus widths used by the computer top.
package mem_dump_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DATA_W = 32;

  // Settle and read-latency counter width; both counts stay within 1..15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_FINISH  = 3'd4
  } dump_state_e;

endpackage

// File: rtl/dump_range_ctr.sv
// Current dump address and remaining-word count for an inclusive, wrapping range.
module dump_range_ctr
  import mem_dump_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W-1:0] last_addr_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] cur_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              last_q, last_d;

  // Remaining count is modulo the depth, so LAST < START simply wraps through 0.
  always_comb begin
    cur_d  = cur_q;
    rem_d  = rem_q;
    last_d = last_q;
    if (load_i) begin
      cur_d  = start_addr_i;
      rem_d  = last_addr_i - start_addr_i;
      last_d = (last_addr_i == start_addr_i);
    end else if (step_i && !last_q) begin
      cur_d  = cur_q + 1'b1;
      rem_d  = rem_q - 1'b1;
      last_d = (rem_q == ADDR_W'(1));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_q  <= '0;
      rem_q  <= '0;
      last_q <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      rem_q  <= rem_d;
      last_q <= last_d;
    end
  end

  assign cur_o  = cur_q;
  assign last_o = last_q;

endmodule

// File: rtl/mem_dump_ctrl.sv
// Halts the computer, walks its debug read port over an address range and streams
// each captured word, tagged with its address, over a valid/ready interface.
module mem_dump_ctrl
  import mem_dump_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned SETTLE = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W-1:0] last_addr_i,
  input  logic              abort_i,
  output logic              hlt_o,
  output logic [ADDR_W-1:0] dbg_addr_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              busy_o,
  output logic              done_o
);

  dump_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] dbg_addr_q, dbg_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              hlt_q, busy_q, valid_q, done_q;

  logic              rng_load, rng_step;
  logic [ADDR_W-1:0] cur;
  logic              last_word;

  dump_range_ctr #(
    .ADDR_W(ADDR_W)
  ) u_range (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (rng_load),
    .start_addr_i(start_addr_i),
    .last_addr_i (last_addr_i),
    .step_i      (rng_step),
    .cur_o       (cur),
    .last_o      (last_word)
  );

  // Next-state logic; the debug address only moves when a read is (re)issued.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dbg_addr_d = dbg_addr_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    rng_load   = 1'b0;
    rng_step   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          rng_load   = 1'b1;
          dbg_addr_d = start_addr_i;
          cnt_d      = '0;
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          cnt_d      = '0;
          out_data_d = data_i;
          out_addr_d = cur;
          state_d    = ST_PRESENT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PRESENT: begin
        if (out_ready_i) begin
          if (last_word) begin
            state_d = ST_FINISH;
          end else begin
            rng_step   = 1'b1;
            dbg_addr_d = cur + 1'b1;
            state_d    = ST_WAIT;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Abort overrides everything, including a same-cycle handshake.
    if (abort_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dbg_addr_q <= '0;
      out_data_q <= '0;
      out_addr_q <= '0;
      hlt_q      <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dbg_addr_q <= dbg_addr_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
      hlt_q      <= (state_d == ST_SETTLE) || (state_d == ST_WAIT) || (state_d == ST_PRESENT);
      busy_q     <= (state_d != ST_IDLE);
      valid_q    <= (state_d == ST_PRESENT);
      done_q     <= (state_d == ST_FINISH);
    end
  end

  assign hlt_o       = hlt_q;
  assign dbg_addr_o  = dbg_addr_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = out_data_q;
  assign out_addr_o  = out_addr_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
